// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor elevator controller serving latched calls in SCAN order,
// with an internal move-tick divider and a timed, extendable door phase.
module elevator_scan_ctrl #(
  parameter int unsigned FLOORS     = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned DOOR_TICKS = 3,
  localparam int unsigned FW        = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [FLOORS-1:0] call_req,
  output logic [FW-1:0]     floor,
  output logic [FLOORS-1:0] floor_onehot,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] pending,
  output logic              arrive
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [FLOORS-1:0] onehot_q, onehot_d;
  logic              dir_up_q, dir_up_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic              arrive_q, arrive_d;
  logic              moving_q, moving_d;
  logic              door_open_q, door_open_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     door_cnt_q, door_cnt_d;

  logic              tick;
  logic              above, below;
  logic              go_ahead, go_back;
  logic              do_decide;
  logic              new_dir;

  // Move-tick divider: free-running while enabled, frozen otherwise.
  always_comb begin
    tick  = ena && (cnt_q == TICK_LAST);
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Calls pending strictly above / below the cab, relative to the travel direction.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q)) above = 1'b1;
        if (i < int'(floor_q)) below = 1'b1;
      end
    end
    go_ahead = dir_up_q ? above : below;
    go_back  = dir_up_q ? below : above;
  end

  // Next-state logic: call latching, door timing and the SCAN decision.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    door_cnt_d = door_cnt_q;
    arrive_d   = 1'b0;
    do_decide  = 1'b0;
    new_dir    = dir_up_q;
    // With the door open, a call for this floor is served on the spot, never latched.
    pending_d  = pending_q | (call_req & ~((state_q == S_DOOR) ? onehot_q : '0));

    if (tick) begin
      case (state_q)
        S_IDLE, S_MOVE: do_decide = 1'b1;
        S_DOOR: begin
          if (call_req[floor_q]) begin
            door_cnt_d = DOOR_LOAD;
          end else if (door_cnt_q != '0) begin
            door_cnt_d = door_cnt_q - DW'(1);
          end else begin
            do_decide = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_decide) begin
      if (pending_q[floor_q]) begin
        state_d    = S_DOOR;
        door_cnt_d = DOOR_LOAD;
        pending_d  = pending_d & ~onehot_q;
      end else if (go_ahead || go_back) begin
        new_dir  = go_ahead ? dir_up_q : ~dir_up_q;
        dir_up_d = new_dir;
        state_d  = S_MOVE;
        floor_d  = new_dir ? floor_q + FW'(1) : floor_q - FW'(1);
        arrive_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    onehot_d    = FLOORS'(1) << floor_d;
    moving_d    = (state_d == S_MOVE);
    door_open_d = (state_d == S_DOOR);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      floor_q     <= '0;
      onehot_q    <= FLOORS'(1);
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      arrive_q    <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      cnt_q       <= '0;
      door_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      onehot_q    <= onehot_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      arrive_q    <= arrive_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      cnt_q       <= cnt_d;
      door_cnt_q  <= door_cnt_d;
    end
  end

  assign floor        = floor_q;
  assign floor_onehot = onehot_q;
  assign dir_up       = dir_up_q;
  assign moving       = moving_q;
  assign door_open    = door_open_q;
  assign pending      = pending_q;
  assign arrive       = arrive_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random calls against a behavioural model.
module tb_elevator_scan_ctrl;

  localparam int unsigned FLOORS     = 4;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned DOOR_TICKS = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [FLOORS-1:0] call_req;
  logic [1:0]        floor;
  logic [FLOORS-1:0] floor_onehot;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic              arrive;

  elevator_scan_ctrl #(
    .FLOORS    (FLOORS),
    .TICK_DIV  (TICK_DIV),
    .DOOR_TICKS(DOOR_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .call_req    (call_req),
    .floor       (floor),
    .floor_onehot(floor_onehot),
    .dir_up      (dir_up),
    .moving      (moving),
    .door_open   (door_open),
    .pending     (pending),
    .arrive      (arrive)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: phase 0 = idle, 1 = travelling, 2 = door open.
  int m_floor;
  bit m_dir;
  int m_phase;
  bit m_pend[FLOORS];
  int m_door_left;
  int m_en_clks;
  bit m_arrive;

  int door_log[$];
  bit prev_door;
  bit saw_move;
  int held_floor;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_floor     = 0;
    m_dir       = 1'b1;
    m_phase     = 0;
    m_door_left = 0;
    m_en_clks   = 0;
    m_arrive    = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++) m_pend[i] = 1'b0;
  endtask

  // Advances the model across one clock edge with the given inputs.
  task automatic model_clk(input logic [FLOORS-1:0] req, input logic en);
    bit old[FLOORS];
    bit tick;
    bit decide;
    bit up_calls;
    bit dn_calls;
    old      = m_pend;
    m_arrive = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++)
      if (req[i] && !(m_phase == 2 && i == m_floor)) m_pend[i] = 1'b1;
    tick = 1'b0;
    if (en) begin
      m_en_clks++;
      tick = (m_en_clks % TICK_DIV) == 0;
    end
    if (tick) begin
      decide = 1'b1;
      if (m_phase == 2) begin
        if (req[m_floor]) begin
          m_door_left = DOOR_TICKS - 1;
          decide      = 1'b0;
        end else if (m_door_left > 0) begin
          m_door_left--;
          decide = 1'b0;
        end
      end
      if (decide) begin
        up_calls = 1'b0;
        dn_calls = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
          if (old[i] && i > m_floor) up_calls = 1'b1;
          if (old[i] && i < m_floor) dn_calls = 1'b1;
        end
        if (old[m_floor]) begin
          m_phase          = 2;
          m_door_left      = DOOR_TICKS - 1;
          m_pend[m_floor]  = 1'b0;
        end else if (up_calls || dn_calls) begin
          if (m_dir ? !up_calls : !dn_calls) m_dir = !m_dir;
          m_floor  = m_floor + (m_dir ? 1 : -1);
          m_phase  = 1;
          m_arrive = 1'b1;
        end else begin
          m_phase = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < int'(FLOORS); i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic compare_all();
    check("floor",     32'(floor),        32'(m_floor));
    check("onehot",    32'(floor_onehot), 32'(1) << m_floor);
    check("dir_up",    32'(dir_up),       32'(m_dir));
    check("moving",    32'(moving),       32'(m_phase == 1));
    check("door_open", 32'(door_open),    32'(m_phase == 2));
    check("pending",   32'(pending),      model_pend());
    check("arrive",    32'(arrive),       32'(m_arrive));
    check("exclusive", 32'(moving & door_open), 32'(0));
  endtask

  // One clock: drive at the falling edge, let the rising edge act, compare at the next falling edge.
  task automatic step(input logic [FLOORS-1:0] req, input logic en);
    call_req = req;
    ena      = en;
    model_clk(req, en);
    @(negedge clk);
    compare_all();
    if (door_open && !prev_door) door_log.push_back(int'(floor));
    prev_door = door_open;
    if (moving) saw_move = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_floor"},   32'(floor),        32'(0));
    check({tag, "_onehot"},  32'(floor_onehot), 32'(1));
    check({tag, "_dir"},     32'(dir_up),       32'(1));
    check({tag, "_moving"},  32'(moving),       32'(0));
    check({tag, "_door"},    32'(door_open),    32'(0));
    check({tag, "_pending"}, 32'(pending),      32'(0));
    check({tag, "_arrive"},  32'(arrive),       32'(0));
  endtask

  // Reset asserted between edges must clear outputs before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    prev_door = 1'b0;
  endtask

  task automatic wait_door(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!door_open && n < max_cycles) begin
      step('0, 1'b1);
      n++;
    end
    check({tag, "_door_reached"}, 32'(door_open), 32'(1));
  endtask

  task automatic wait_moving(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!moving && n < max_cycles) begin
      step('0, 1'b1);
      n++;
    end
    check({tag, "_moving_reached"}, 32'(moving), 32'(1));
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b0;
    call_req  = '0;
    prev_door = 1'b0;
    saw_move  = 1'b0;
    model_reset();
    #2;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;

    // Call at the current idle floor: door opens without any motion.
    step(4'b0001, 1'b1);
    repeat (8) step('0, 1'b1);
    check("idle_call_log_size", 32'(door_log.size()), 32'(1));
    if (door_log.size() > 0) check("idle_call_floor", 32'(door_log[0]), 32'(0));
    check("idle_call_no_move", 32'(saw_move), 32'(0));
    repeat (12) step('0, 1'b1);
    check("idle_call_closed", 32'(door_open), 32'(0));

    // Single call two floors up.
    door_log.delete();
    step(4'b0100, 1'b1);
    repeat (28) step('0, 1'b1);
    check("single_log_size", 32'(door_log.size()), 32'(1));
    if (door_log.size() > 0) check("single_floor", 32'(door_log[0]), 32'(2));
    check("single_end_floor", 32'(floor), 32'(2));
    check("single_end_idle",  32'(door_open | moving), 32'(0));

    // Async reset mid-move, then first tick lands on the TICK_DIV-th enabled clock.
    step(4'b0001, 1'b1);
    wait_moving("pre_reset", 20);
    async_reset("mid_move");
    step(4'b1000, 1'b1);
    step('0, 1'b1);
    step('0, 1'b1);
    check("first_tick_not_early", 32'(floor), 32'(0));
    step('0, 1'b1);
    check("first_tick_floor",  32'(floor),  32'(1));
    check("first_tick_arrive", 32'(arrive), 32'(1));
    check("first_tick_moving", 32'(moving), 32'(1));

    // SCAN: at floor 1 heading up, calls at 0 and 3 -> serve 3, then reverse to 0.
    door_log.delete();
    step(4'b1001, 1'b1);
    repeat (60) step('0, 1'b1);
    check("scan_log_size", 32'(door_log.size()), 32'(2));
    if (door_log.size() > 1) begin
      check("scan_first",  32'(door_log[0]), 32'(3));
      check("scan_second", 32'(door_log[1]), 32'(0));
    end
    check("scan_dir_down", 32'(dir_up), 32'(0));
    check("scan_end_floor", 32'(floor), 32'(0));

    // Door extend: keep calling the open floor, then release.
    step(4'b0100, 1'b1);
    wait_door("extend", 60);
    for (int k = 0; k < 16; k++) begin
      step(4'b0100, 1'b1);
      check("extend_held_open", 32'(door_open), 32'(1));
    end
    repeat (20) step('0, 1'b1);
    check("extend_closed",  32'(door_open), 32'(0));
    check("extend_pending", 32'(pending),   32'(0));

    // ena low while moving freezes motion but not call latching.
    step(4'b0001, 1'b1);
    wait_moving("freeze", 20);
    held_floor = int'(floor);
    for (int k = 0; k < 20; k++) step((k == 5) ? 4'b1000 : 4'b0000, 1'b0);
    check("freeze_floor",   32'(floor),      32'(held_floor));
    check("freeze_moving",  32'(moving),     32'(1));
    check("freeze_latched", 32'(pending[3]), 32'(1));
    repeat (60) step('0, 1'b1);

    // Random traffic with a reset dropped in partway.
    for (int k = 0; k < 600; k++) begin
      logic [FLOORS-1:0] r;
      logic              e;
      r = ($urandom_range(0, 5) == 0) ? FLOORS'($urandom) : '0;
      e = ($urandom_range(0, 9) != 0);
      step(r, e);
      if (k == 300) async_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
